// File: rtl/layer_compositor.sv
// Two-stage N-layer pixel compositor with colour-key transparency and
// per-frame layer-0 overlap reporting for the VGA game path.
module layer_compositor #(
    parameter int                 NUM_LAYERS = 6,
    parameter int                 RGB_W      = 12,
    parameter int                 KEY_EN     = 1,
    parameter logic [RGB_W-1:0]   KEY_RGB    = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pix_valid,
    input  logic                        frame_start,
    input  logic [1:0]                  mode,
    input  logic [NUM_LAYERS-1:0]       layer_mask,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [RGB_W-1:0]            splash_rgb,
    output logic [RGB_W-1:0]            rgb_out,
    output logic                        rgb_valid,
    output logic [NUM_LAYERS-1:0]       collide_vec,
    output logic                        boom
);

    localparam logic [1:0] MODE_PLAY   = 2'd0;
    localparam logic [1:0] MODE_SPLASH = 2'd1;

    logic [NUM_LAYERS-1:0]       op;
    logic [NUM_LAYERS-1:0]       op_q;
    logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0]            bg_q;
    logic [RGB_W-1:0]            splash_q;
    logic [1:0]                  mode_q;
    logic                        valid_q;
    logic                        fs_q;
    logic [RGB_W-1:0]            pick;
    logic [NUM_LAYERS-1:1]       hit;
    logic [NUM_LAYERS-1:1]       acc;

    always_comb begin
        op = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            op[i] = layer_en[i] & layer_mask[i]
                  & ~((KEY_EN != 0) && (layer_rgb[i*RGB_W +: RGB_W] == KEY_RGB));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            rgb_q    <= '0;
            bg_q     <= '0;
            splash_q <= '0;
            mode_q   <= MODE_PLAY;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            op_q     <= op;
            rgb_q    <= layer_rgb;
            bg_q     <= bg_rgb;
            splash_q <= splash_rgb;
            mode_q   <= mode;
            valid_q  <= pix_valid;
            fs_q     <= frame_start;
        end
    end

    // Walk from lowest priority upward so layer 0 wins last.
    always_comb begin
        pick = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (op_q[i]) pick = rgb_q[i*RGB_W +: RGB_W];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_out   <= '0;
            rgb_valid <= 1'b0;
        end else begin
            rgb_valid <= valid_q;
            if (!valid_q)
                rgb_out <= '0;
            else if (mode_q == MODE_PLAY)
                rgb_out <= pick;
            else if (mode_q == MODE_SPLASH)
                rgb_out <= splash_q;
            else
                rgb_out <= '0;
        end
    end

    assign hit = op_q[NUM_LAYERS-1:1]
               & {(NUM_LAYERS-1){op_q[0] & valid_q & (mode_q == MODE_PLAY)}};

    // The pixel sharing a cycle with frame_start seeds the new frame's accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            collide_vec <= '0;
            boom        <= 1'b0;
        end else if (fs_q) begin
            collide_vec <= {acc, 1'b0};
            boom        <= |acc;
            acc         <= hit;
        end else begin
            acc         <= acc | hit;
            boom        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: pixel scoreboard plus collision-report checks.
module tb_layer_compositor;

    localparam int NL = 6;
    localparam int RW = 12;

    typedef struct packed {
        logic [RW-1:0] rgb;
        logic          valid;
    } px_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pix_valid = 1'b0;
    logic            frame_start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [NL-1:0]   layer_mask = '1;
    logic [NL-1:0]   layer_en = '0;
    logic [RW-1:0]   lrgb [NL];
    logic [NL*RW-1:0] layer_rgb;
    logic [RW-1:0]   bg_rgb = 12'h123;
    logic [RW-1:0]   splash_rgb = 12'hABC;
    logic [RW-1:0]   rgb_out;
    logic            rgb_valid;
    logic [NL-1:0]   collide_vec;
    logic            boom;

    int vectors = 0;
    int miscompares = 0;
    px_t sb [$];

    always #20 clk = ~clk;

    always_comb begin
        layer_rgb = '0;
        for (int i = 0; i < NL; i++) layer_rgb[i*RW +: RW] = lrgb[i];
    end

    layer_compositor #(.NUM_LAYERS(NL), .RGB_W(RW), .KEY_EN(1), .KEY_RGB(12'h000)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .frame_start(frame_start),
        .mode(mode), .layer_mask(layer_mask), .layer_en(layer_en), .layer_rgb(layer_rgb),
        .bg_rgb(bg_rgb), .splash_rgb(splash_rgb), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
        .collide_vec(collide_vec), .boom(boom)
    );

    function automatic px_t model();
        px_t p;
        p.valid = pix_valid;
        p.rgb   = '0;
        if (pix_valid) begin
            if (mode == 2'd1) p.rgb = splash_rgb;
            else if (mode == 2'd0) begin
                p.rgb = bg_rgb;
                for (int i = 0; i < NL; i++) begin
                    if (layer_en[i] && layer_mask[i] && lrgb[i] != 12'h000) begin
                        p.rgb = lrgb[i];
                        break;
                    end
                end
            end
        end
        return p;
    endfunction

    task automatic check_px();
        px_t e;
        e = sb.pop_front();
        vectors++;
        assert (rgb_out === e.rgb) else begin
            miscompares++;
            $error("FAIL rgb_out got %h want %h", rgb_out, e.rgb);
        end
        vectors++;
        assert (rgb_valid === e.valid) else begin
            miscompares++;
            $error("FAIL rgb_valid got %b want %b", rgb_valid, e.valid);
        end
    endtask

    task automatic step();
        sb.push_back(model());
        @(posedge clk);
        #1;
        if (sb.size() >= 2) check_px();
    endtask

    task automatic check_coll(input string tag, input logic [NL-1:0] cv, input logic bm);
        vectors++;
        assert (collide_vec === cv) else begin
            miscompares++;
            $error("FAIL %s collide_vec got %b want %b", tag, collide_vec, cv);
        end
        vectors++;
        assert (boom === bm) else begin
            miscompares++;
            $error("FAIL %s boom got %b want %b", tag, boom, bm);
        end
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        assert (rgb_out === '0 && rgb_valid === 1'b0) else begin
            miscompares++;
            $error("FAIL %s rgb got %h/%b want 000/0", tag, rgb_out, rgb_valid);
        end
        check_coll(tag, '0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NL; i++) lrgb[i] = 12'h000;
        #5;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Priority: layer 1 beats layer 2
        pix_valid = 1; mode = 0; layer_mask = 6'h3F; layer_en = 6'b000110;
        lrgb[1] = 12'hF00; lrgb[2] = 12'h0F0;
        step();
        // Colour key and mask fall-through
        layer_en = 6'b000011; lrgb[0] = 12'h000; lrgb[1] = 12'h00F;
        step();
        layer_mask = 6'b111101;
        step();
        // Modes and blanking
        layer_mask = 6'h3F; mode = 1;
        step();
        mode = 2;
        step();
        mode = 3;
        step();
        mode = 0; pix_valid = 0;
        step();
        pix_valid = 1; layer_en = 6'b100100; lrgb[5] = 12'h555; lrgb[2] = 12'h0F0;
        step();

        // Collision: clean start, one overlap, report
        layer_en = '0; frame_start = 1;
        step();
        frame_start = 0; layer_en = 6'b001001; lrgb[0] = 12'hFFF; lrgb[3] = 12'h0F0;
        step();
        layer_en = '0;
        step();
        step();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("overlap_report", 6'b001000, 1'b1);
        step();
        check_coll("boom_one_cycle", 6'b001000, 1'b0);
        repeat (3) step();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("clean_frame", 6'b000000, 1'b0);

        // Overlap coincident with frame_start belongs to the new frame
        layer_en = 6'b001001; frame_start = 1;
        step();
        layer_en = '0; frame_start = 0;
        step();
        check_coll("same_cycle_excluded", 6'b000000, 1'b0);
        repeat (2) step();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("same_cycle_next", 6'b001000, 1'b1);

        // Overlap in SPLASH never counts
        mode = 1; layer_en = 6'b011001; lrgb[4] = 12'h444;
        step();
        mode = 0; layer_en = '0;
        step();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("splash_ignored", 6'b000000, 1'b0);

        // Mid-frame reset after a reported and a pending overlap
        layer_en = 6'b100001; lrgb[5] = 12'h555;
        step();
        layer_en = '0; frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("pre_reset_report", 6'b100000, 1'b1);
        layer_en = 6'b000011; lrgb[1] = 12'h00F;
        step();
        layer_en = '0;
        step();
        #3 rst = 1'b0;
        #1 check_zero("async_reset");
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        step();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        check_coll("post_reset_frame", 6'b000000, 1'b0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
